// File: rtl/rf_pkg.sv
// Shared types and default sizes for the 2-read / 1-write register file.
package rf_pkg;

    localparam int RF_WIDTH_DEF = 8;
    localparam int RF_DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEARING = 2'd1,
        DONE     = 2'd2
    } rf_clr_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks a counter over every entry, emitting one zero-write per cycle.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_clr_state_t     r_state;
    rf_clr_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: leave CLEARING on the edge that zeroes the last entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (i_clr) w_state_nxt = CLEARING;
            CLEARING: if (r_cnt == LAST) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Counter: zeroed on clear start, saturates at LAST so it never indexes past DEPTH-1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                r_cnt <= '0;
        else if (r_state == IDLE && i_clr)           r_cnt <= '0;
        else if (r_state == CLEARING && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
    end

    // Outputs decoded from state
    always_comb begin
        o_busy     = (r_state == CLEARING);
        o_clr_done = (r_state == DONE);
        o_clr_we   = (r_state == CLEARING);
        o_clr_addr = r_cnt;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: 2 registered read ports, 1 write port, bulk clear.
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re_a,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [WIDTH-1:0]  o_rdata_a,
    input  logic              i_re_b,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [WIDTH-1:0]  o_rdata_b,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_done
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [1:0][WIDTH-1:0]       r_rdata;

    logic                        w_busy;
    logic                        w_clr_we;
    logic [ADDR_W-1:0]           w_clr_addr;
    logic                        w_wr_ok;
    logic [1:0]                  w_re;
    logic [1:0][ADDR_W-1:0]      w_raddr;
    logic [1:0][WIDTH-1:0]       w_rd;

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .o_busy     (w_busy),
        .o_clr_done (o_clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Write acceptance: blocked while clearing, out of range, or targeting hardwired zero
    always_comb begin
        w_wr_ok = i_we && !w_busy && (int'(i_waddr) < DEPTH) &&
                  !((ZERO_REG != 0) && (i_waddr == '0));
    end

    // Storage: clear engine owns the write port while busy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_mem <= '0;
        else if (w_clr_we) r_mem[w_clr_addr] <= '0;
        else if (w_wr_ok)  r_mem[i_waddr] <= i_wdata;
    end

    assign w_re    = {i_re_b, i_re_a};
    assign w_raddr = {i_raddr_b, i_raddr_a};

    // Read mux per port: range/zero-reg masking, then optional same-edge forwarding
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < 2; p++) begin
            if ((int'(w_raddr[p]) < DEPTH) && !((ZERO_REG != 0) && (w_raddr[p] == '0))) begin
                if ((BYPASS != 0) && w_wr_ok && (i_waddr == w_raddr[p])) w_rd[p] = i_wdata;
                else                                                     w_rd[p] = r_mem[w_raddr[p]];
            end
        end
    end

    // Registered read data; holds when the port is not enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else begin
            for (int p = 0; p < 2; p++)
                if (w_re[p]) r_rdata[p] <= w_rd[p];
        end
    end

    assign o_rdata_a = r_rdata[0];
    assign o_rdata_b = r_rdata[1];
    assign o_busy    = w_busy;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: two instances share stimulus.
//   u0: DEPTH=32, BYPASS=1, ZERO_REG=0
//   u1: DEPTH=20, BYPASS=0, ZERO_REG=1
module tb_reg_file_2r1w;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we, re_a, re_b, clr;
    logic [4:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;

    logic [7:0] a0, b0, a1, b1;
    logic       busy0, done0, busy1, done1;

    int ncmp = 0;
    int nerr = 0;
    int bc0, bc1, dc0, dc1;

    always #5 clk = ~clk;

    reg_file_2r1w u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(a0),
        .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(b0),
        .i_clr(clr), .o_busy(busy0), .o_clr_done(done0)
    );

    reg_file_2r1w #(.DEPTH(20), .BYPASS(0), .ZERO_REG(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(a1),
        .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(b1),
        .i_clr(clr), .o_busy(busy1), .o_clr_done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we = 0; re_a = 0; re_b = 0; clr = 0;
        waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        #12;
        chk("rst_a0", a0, 8'h00); chk("rst_b0", b0, 8'h00);
        chk("rst_a1", a1, 8'h00); chk("rst_b1", b1, 8'h00);
        chk("rst_busy", {6'd0, busy0, busy1}, 8'h00);
        chk("rst_done", {6'd0, done0, done1}, 8'h00);
        rst_n = 1;

        // basic write then read
        we = 1; waddr = 3; wdata = 8'hA5; tick();
        we = 0; re_a = 1; raddr_a = 3; tick();
        chk("rd3_a0", a0, 8'hA5); chk("rd3_a1", a1, 8'hA5);
        re_a = 0;

        // same-edge write/read of reg 5 (prior value 0x11)
        we = 1; waddr = 5; wdata = 8'h11; tick();
        wdata = 8'h3C; re_a = 1; re_b = 1; raddr_a = 5; raddr_b = 5; tick();
        chk("byp_a0", a0, 8'h3C); chk("byp_b0", b0, 8'h3C);
        chk("nobyp_a1", a1, 8'h11); chk("nobyp_b1", b1, 8'h11);
        we = 0; re_b = 0; tick();
        chk("post5_a0", a0, 8'h3C); chk("post5_a1", a1, 8'h3C);
        re_a = 0;

        // zero register and out-of-range address
        we = 1; waddr = 0; wdata = 8'hFF; tick();
        we = 0; re_a = 1; raddr_a = 0; tick();
        chk("r0_a0", a0, 8'hFF); chk("r0_a1", a1, 8'h00);
        re_a = 0; we = 1; waddr = 25; wdata = 8'h77; tick();
        we = 0; re_a = 1; raddr_a = 25; tick();
        chk("r25_a0", a0, 8'h77); chk("r25_a1", a1, 8'h00);

        // read enable low holds data while contents change
        raddr_a = 3; tick();
        chk("hold_pre_a0", a0, 8'hA5);
        re_a = 0; we = 1; waddr = 3; wdata = 8'h5A; tick();
        we = 0; tick(); tick();
        chk("hold_a0", a0, 8'hA5); chk("hold_a1", a1, 8'hA5);
        re_a = 1; tick();
        chk("upd_a0", a0, 8'h5A); chk("upd_a1", a1, 8'h5A);
        re_a = 0;

        // fill every register
        for (int i = 0; i < 32; i++) begin
            we = 1; waddr = 5'(i); wdata = 8'(8'h40 + i); tick();
        end
        // CLR sampled together with a write to reg 7 (write happens, clear later zeroes it)
        we = 1; waddr = 7; wdata = 8'h22; clr = 1; tick();
        chk("busy0_start", {7'd0, busy0}, 8'h01); chk("busy1_start", {7'd0, busy1}, 8'h01);
        bc0 = 1; bc1 = 1; dc0 = 0; dc1 = 0;
        // write during busy is dropped; read during busy sees current contents
        clr = 0; we = 1; waddr = 7; wdata = 8'h11; re_a = 1; raddr_a = 31; tick();
        chk("busyrd_a0", a0, 8'h5F); chk("busyrd_a1", a1, 8'h00);
        bc0 += int'(busy0); bc1 += int'(busy1);
        we = 0; re_a = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            bc0 += int'(busy0); bc1 += int'(busy1);
            dc0 += int'(done0); dc1 += int'(done1);
        end
        chk("busy_cycles0", 8'(bc0), 8'd32); chk("busy_cycles1", 8'(bc1), 8'd20);
        chk("done_pulses0", 8'(dc0), 8'd1);  chk("done_pulses1", 8'(dc1), 8'd1);
        for (int i = 0; i < 32; i++) begin
            re_a = 1; re_b = 1; raddr_a = 5'(i); raddr_b = 5'(31 - i); tick();
            chk($sformatf("clr_a0_%0d", i), a0, 8'h00);
            chk($sformatf("clr_b0_%0d", i), b0, 8'h00);
            chk($sformatf("clr_a1_%0d", i), a1, 8'h00);
        end
        re_a = 0; re_b = 0;

        // reset in the middle of a clear
        we = 1; waddr = 2; wdata = 8'h99; tick();
        we = 0; re_a = 1; raddr_a = 2; tick();
        chk("pre_rst_a0", a0, 8'h99);
        re_a = 0; clr = 1; tick();
        clr = 0;
        for (int k = 0; k < 9; k++) tick();
        chk("midclr_busy0", {7'd0, busy0}, 8'h01);
        rst_n = 0; #2;
        chk("arst_a0", a0, 8'h00); chk("arst_a1", a1, 8'h00);
        chk("arst_busy", {6'd0, busy0, busy1}, 8'h00);
        chk("arst_done", {6'd0, done0, done1}, 8'h00);
        tick();
        rst_n = 1;
        dc0 = 0; bc0 = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            dc0 += int'(done0) + int'(done1);
            bc0 += int'(busy0) + int'(busy1);
        end
        chk("no_done_after_abort", 8'(dc0), 8'd0);
        chk("no_busy_after_abort", 8'(bc0), 8'd0);
        re_a = 1; raddr_a = 2; tick();
        chk("rst_cleared_a0", a0, 8'h00);
        re_a = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
